// File: rtl/lsu_pipe_exec_pkg.sv
// Shared types and constants for the load/store execution unit.
// Contents: access size enum, CDB broadcast struct, the misaligned-load
// poison value, and a helper that maps the raw 2-bit size field onto
// the enum. The raw encoding 2'b11 is treated as a word access.
package lsu_pipe_exec_pkg;

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10
    } ls_size_t;

    localparam int CDB_TAG_W = 6;

    typedef struct packed {
        logic                 valid;
        logic [CDB_TAG_W-1:0] tag;
        logic [31:0]          result;
        logic                 branch;
        logic                 branch_taken;
    } cdb_bfm;

    localparam logic [31:0] LSU_MISALIGN_DATA = 32'hDEAD_BEEF;

    function automatic ls_size_t decode_size(input logic [1:0] raw);
        ls_size_t s;
        case (raw)
            2'b00:   s = LS_BYTE;
            2'b01:   s = LS_HALF;
            default: s = LS_WORD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lsu_pipe_exec_if.sv
// Issue and CDB signals of the load/store unit.
// master: the issue queue / CDB arbiter side (drives i_*, observes o_*).
// slave:  the execution unit (observes i_*, drives o_*).
interface lsu_pipe_exec_if #(
    parameter int TAG_WIDTH  = 6,
    parameter int DATA_WIDTH = 32
);
    logic                  i_issue_valid;
    logic                  o_issue_ready;
    logic                  i_ld_st_opcode;
    logic [1:0]            i_size;
    logic                  i_unsigned;
    logic [DATA_WIDTH-1:0] i_rs1_data;
    logic [DATA_WIDTH-1:0] i_rs2_data;
    logic [DATA_WIDTH-1:0] i_immediate;
    logic [TAG_WIDTH-1:0]  i_rd_tag;
    logic                  i_cdb_grant;
    logic                  o_cdb_valid;
    logic [TAG_WIDTH-1:0]  o_cdb_tag;
    logic [DATA_WIDTH-1:0] o_cdb_result;
    logic                  o_cdb_branch;
    logic                  o_cdb_branch_taken;

    modport master (
        output i_issue_valid, i_ld_st_opcode, i_size, i_unsigned,
               i_rs1_data, i_rs2_data, i_immediate, i_rd_tag, i_cdb_grant,
        input  o_issue_ready, o_cdb_valid, o_cdb_tag, o_cdb_result,
               o_cdb_branch, o_cdb_branch_taken
    );

    modport slave (
        input  i_issue_valid, i_ld_st_opcode, i_size, i_unsigned,
               i_rs1_data, i_rs2_data, i_immediate, i_rd_tag, i_cdb_grant,
        output o_issue_ready, o_cdb_valid, o_cdb_tag, o_cdb_result,
               o_cdb_branch, o_cdb_branch_taken
    );
endinterface

// File: rtl/lsu_pipe_exec_result_fifo.sv
// lsu_result_fifo: synchronous FIFO holding completed load results.
// Ports: clk, rst_n (async active-low), push/push_data, pop, head_data
// (head entry, zero while empty), count (occupancy).
// The caller guarantees no push while full and no pop while empty.
module lsu_result_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

endmodule

// File: rtl/lsu_pipe_exec.sv
// lsu_pipe_exec: load/store execution unit. Computes rs1 + imm, writes
// stores into an internal word RAM with byte enables, reads loads
// combinationally, extends them, and carries {tag, data} through a
// LATENCY-stage pipeline into a credit-limited result FIFO that feeds
// the CDB.
// Ports: clk, rst_n (async active-low), bus (lsu_pipe_exec_if.slave:
// issue handshake, operands, CDB grant and CDB result outputs).
// Build option: LSU_MISALIGN_CHK_EN -- when defined, misaligned half/word
// accesses are suppressed (stores dropped, loads return 0xDEADBEEF);
// when undefined they are aligned down and executed.
module lsu_pipe_exec
    import lsu_pipe_exec_pkg::*;
#(
    parameter int LATENCY    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int TAG_WIDTH  = 6,
    parameter int OUT_DEPTH  = 2
) (
    input logic           clk,
    input logic           rst_n,
    lsu_pipe_exec_if.slave bus
);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int EW = TAG_WIDTH + DATA_WIDTH;

    logic [DATA_WIDTH-1:0] addr, wdata, rd_word, ld_data;
    logic [ADDR_WIDTH-1:0] widx;
    logic [1:0]            lane;
    logic [3:0]            be;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    ls_size_t              size;
    logic                  misaligned, issue_ready, accept, ld_acc, st_acc, pop;
    logic                  unused_addr;
    logic [CW-1:0]         credit_q, credit_d, fifo_cnt;
    logic [EW-1:0]         head;

    logic [DATA_WIDTH-1:0] ram_q [2**ADDR_WIDTH];

    logic                  pipe_vld_q [LATENCY];
    logic                  pipe_vld_d [LATENCY];
    logic [EW-1:0]         pipe_ent_q [LATENCY];
    logic [EW-1:0]         pipe_ent_d [LATENCY];

    assign addr        = bus.i_rs1_data + bus.i_immediate;
    assign widx        = addr[ADDR_WIDTH+1:2];
    assign lane        = addr[1:0];
    // Address bits above the RAM index alias onto the same words.
    assign unused_addr = ^addr[DATA_WIDTH-1:ADDR_WIDTH+2];
    assign size        = decode_size(bus.i_size);

`ifdef LSU_MISALIGN_CHK_EN
    assign misaligned = ((size == LS_HALF) && lane[0]) ||
                        ((size == LS_WORD) && (lane != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Credits cover loads both in flight and buffered, so the FIFO never overflows.
    assign issue_ready = (credit_q < CW'(OUT_DEPTH));
    assign accept      = bus.i_issue_valid && issue_ready;
    assign ld_acc      = accept && !bus.i_ld_st_opcode;
    assign st_acc      = accept && bus.i_ld_st_opcode && !misaligned;
    assign pop         = bus.i_cdb_grant && (fifo_cnt != '0);

    always_comb begin
        be    = 4'b0000;
        wdata = '0;
        case (size)
            LS_BYTE: begin
                be    = 4'b0001 << lane;
                wdata = {4{bus.i_rs2_data[7:0]}};
            end
            LS_HALF: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.i_rs2_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = bus.i_rs2_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (st_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram_q[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rd_word = ram_q[widx];
    assign ld_byte = rd_word[{lane, 3'b000} +: 8];
    assign ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_data = rd_word;
        case (size)
            LS_BYTE: ld_data = {{24{~bus.i_unsigned & ld_byte[7]}}, ld_byte};
            LS_HALF: ld_data = {{16{~bus.i_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = rd_word;
        endcase
        if (misaligned) ld_data = LSU_MISALIGN_DATA;
    end

    always_comb begin
        pipe_vld_d[0] = ld_acc;
        pipe_ent_d[0] = {bus.i_rd_tag, ld_data};
        for (int k = 1; k < LATENCY; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1];
            pipe_ent_d[k] = pipe_ent_q[k-1];
        end
    end

    always_comb begin
        credit_d = credit_q;
        if (ld_acc && !pop)      credit_d = credit_q + 1'b1;
        else if (!ld_acc && pop) credit_d = credit_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LATENCY; k++) begin
                pipe_vld_q[k] <= 1'b0;
                pipe_ent_q[k] <= '0;
            end
            credit_q <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            pipe_ent_q <= pipe_ent_d;
            credit_q   <= credit_d;
        end
    end

    lsu_result_fifo #(
        .WIDTH (EW),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pipe_vld_q[LATENCY-1]),
        .push_data (pipe_ent_q[LATENCY-1]),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_cnt)
    );

    assign bus.o_issue_ready      = issue_ready;
    assign bus.o_cdb_valid        = (fifo_cnt != '0);
    assign bus.o_cdb_tag          = head[EW-1:DATA_WIDTH];
    assign bus.o_cdb_result       = head[DATA_WIDTH-1:0];
    assign bus.o_cdb_branch       = 1'b0;
    assign bus.o_cdb_branch_taken = 1'b0;

endmodule

// File: tb/tb_lsu_pipe_exec.sv
// Self-checking bench for lsu_pipe_exec (LATENCY=2, OUT_DEPTH=2).
// Reference: byte-addressed memory array plus an in-order result queue
// with a visibility cycle per entry and a credit count.
module tb_lsu_pipe_exec;
    localparam int LAT   = 2;
    localparam int DEPTH = 2;

    logic clk, rst_n;
    int   n_cmp, n_bad, cyc, credit;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
        int          vis;
    } ent_t;

    ent_t       q[$];
    logic [7:0] mref [128][4];

    lsu_pipe_exec_if #(.TAG_WIDTH(6), .DATA_WIDTH(32)) bus ();

    lsu_pipe_exec #(
        .LATENCY(LAT), .DATA_WIDTH(32), .ADDR_WIDTH(7), .TAG_WIDTH(6), .OUT_DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
`ifdef LSU_MISALIGN_CHK_EN
        return ((sz == 2'd1) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
        int idx, ln;
        logic [7:0]  b;
        logic [15:0] h;
        idx = int'(a[8:2]);
        ln  = int'(a[1:0]);
        if (ref_misaligned(a, sz)) return 32'hDEADBEEF;
        if (sz == 2'd0) begin
            b = mref[idx][ln];
            return uns ? {24'h0, b} : {{24{b[7]}}, b};
        end
        if (sz == 2'd1) begin
            h = {mref[idx][(ln & 2) + 1], mref[idx][ln & 2]};
            return uns ? {16'h0, h} : {{16{h[15]}}, h};
        end
        return {mref[idx][3], mref[idx][2], mref[idx][1], mref[idx][0]};
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int idx, ln;
        idx = int'(a[8:2]);
        ln  = int'(a[1:0]);
        if (ref_misaligned(a, sz)) return;
        if (sz == 2'd0) mref[idx][ln] = d[7:0];
        else if (sz == 2'd1) begin
            mref[idx][ln & 2]       = d[7:0];
            mref[idx][(ln & 2) + 1] = d[15:8];
        end else begin
            for (int i = 0; i < 4; i++) mref[idx][i] = d[8*i +: 8];
        end
    endtask

    // Drives one cycle of stimulus and advances the reference model.
    task automatic step(input bit v, input bit op, input logic [1:0] sz, input bit uns,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [5:0] tag, input bit gnt, output bit acc);
        bit pop;
        logic [31:0] a;
        ent_t e;
        bus.i_issue_valid  = v;
        bus.i_ld_st_opcode = op;
        bus.i_size         = sz;
        bus.i_unsigned     = uns;
        bus.i_rs1_data     = rs1;
        bus.i_rs2_data     = rs2;
        bus.i_immediate    = imm;
        bus.i_rd_tag       = tag;
        bus.i_cdb_grant    = gnt;
        acc = v && (credit < DEPTH) && rst_n;
        pop = gnt && rst_n && (q.size() > 0) && (q[0].vis <= cyc);
        a   = rs1 + imm;
        @(posedge clk);
        cyc++;
        if (pop) begin
            q.delete(0);
            credit--;
        end
        if (acc) begin
            if (op) ref_store(a, sz, rs2);
            else begin
                e.tag  = tag;
                e.data = ref_load(a, sz, uns);
                e.vis  = cyc + LAT;
                q.push_back(e);
                credit++;
            end
        end
        #1;
        bus.i_issue_valid = 1'b0;
        bus.i_cdb_grant   = 1'b0;
    endtask

    task automatic idle(input bit gnt);
        bit acc;
        step(0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0, 6'd0, gnt, acc);
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (bus.o_cdb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", bus.o_cdb_valid); end
        n_cmp++; if (bus.o_cdb_tag !== 6'd0) begin n_bad++; $display("FAIL reset_tag got %0h want 0", bus.o_cdb_tag); end
        n_cmp++; if (bus.o_cdb_result !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 0", bus.o_cdb_result); end
        n_cmp++; if (bus.o_issue_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0b want 1", bus.o_issue_ready); end
        n_cmp++; if ({bus.o_cdb_branch, bus.o_cdb_branch_taken} !== 2'b00) begin n_bad++; $display("FAIL reset_branch got %b want 00", {bus.o_cdb_branch, bus.o_cdb_branch_taken}); end
        idle(0);
        idle(0);
        rst_n = 1'b1;
        idle(0);
        n_cmp++; if (bus.o_cdb_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid got %0b want 0", bus.o_cdb_valid); end
    endtask

    task automatic test_word_store_load();
        bit acc;
        step(1, 1, 2'd2, 0, 32'h10, 32'h12345678, 32'h4, 6'd0, 0, acc);
        step(1, 0, 2'd2, 0, 32'h10, 32'h0, 32'h4, 6'd5, 0, acc);
        for (int i = 0; i <= LAT; i++) begin
            n_cmp++;
            if (bus.o_cdb_valid !== (i == LAT)) begin
                n_bad++; $display("FAIL sw_lw_latency cycle %0d got %0b want %0b", i, bus.o_cdb_valid, (i == LAT));
            end
            if (i < LAT) idle(0);
        end
        n_cmp++; if (bus.o_cdb_tag !== 6'd5) begin n_bad++; $display("FAIL sw_lw_tag got %0d want 5", bus.o_cdb_tag); end
        n_cmp++; if (bus.o_cdb_result !== 32'h12345678) begin n_bad++; $display("FAIL sw_lw_result got %h want 12345678", bus.o_cdb_result); end
        idle(1);
        n_cmp++; if (bus.o_cdb_valid !== 1'b0) begin n_bad++; $display("FAIL sw_lw_pop got %0b want 0", bus.o_cdb_valid); end
    endtask

    task automatic test_byte_ext();
        bit acc;
        logic [31:0] addrs [3];
        logic [1:0]  szs   [3];
        bit          unss  [3];
        logic [31:0] exps  [3];
        addrs = '{32'h21, 32'h21, 32'h20};
        szs   = '{2'd0, 2'd0, 2'd1};
        unss  = '{1'b0, 1'b1, 1'b0};
        exps  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
        step(1, 1, 2'd2, 0, 32'h20, 32'h000080FF, 32'h0, 6'd0, 0, acc);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, szs[i], unss[i], addrs[i], 32'h0, 32'h0, 6'(20 + i), 0, acc);
            repeat (LAT) idle(0);
            n_cmp++; if (bus.o_cdb_valid !== 1'b1 || bus.o_cdb_tag !== 6'(20 + i)) begin n_bad++; $display("FAIL ext_tag[%0d] got v=%0b tag=%0d want v=1 tag=%0d", i, bus.o_cdb_valid, bus.o_cdb_tag, 20 + i); end
            n_cmp++; if (bus.o_cdb_result !== exps[i]) begin n_bad++; $display("FAIL ext_result[%0d] got %h want %h", i, bus.o_cdb_result, exps[i]); end
            idle(1);
        end
    endtask

    task automatic test_backpressure();
        bit acc;
        n_cmp++; if (bus.o_issue_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready0 got %0b want 1", bus.o_issue_ready); end
        step(1, 0, 2'd2, 0, 32'h14, 32'h0, 32'h0, 6'd11, 0, acc);
        n_cmp++; if (bus.o_issue_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready1 got %0b want 1", bus.o_issue_ready); end
        step(1, 0, 2'd2, 0, 32'h20, 32'h0, 32'h0, 6'd12, 0, acc);
        n_cmp++; if (bus.o_issue_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready2 got %0b want 0", bus.o_issue_ready); end
        step(1, 0, 2'd2, 0, 32'h24, 32'h0, 32'h0, 6'd13, 0, acc);
        idle(0);
        n_cmp++; if (bus.o_issue_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready3 got %0b want 0", bus.o_issue_ready); end
        n_cmp++; if (bus.o_cdb_tag !== 6'd11 || bus.o_cdb_result !== 32'h12345678) begin n_bad++; $display("FAIL bp_first got tag=%0d res=%h want tag=11 res=12345678", bus.o_cdb_tag, bus.o_cdb_result); end
        idle(1);
        n_cmp++; if (bus.o_issue_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_grant got %0b want 1", bus.o_issue_ready); end
        n_cmp++; if (bus.o_cdb_valid !== 1'b1 || bus.o_cdb_tag !== 6'd12 || bus.o_cdb_result !== 32'h000080FF) begin n_bad++; $display("FAIL bp_second got v=%0b tag=%0d res=%h want v=1 tag=12 res=000080ff", bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_result); end
        idle(1);
        n_cmp++; if (bus.o_cdb_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained got %0b want 0 (third load leaked)", bus.o_cdb_valid); end
    endtask

    task automatic test_simul_accept_pop();
        bit acc;
        int got;
        logic [5:0] exp_tags [2];
        exp_tags = '{6'd31, 6'd32};
        step(1, 0, 2'd2, 0, 32'h14, 32'h0, 32'h0, 6'd30, 0, acc);
        repeat (LAT) idle(0);
        n_cmp++; if (bus.o_cdb_valid !== 1'b1 || bus.o_cdb_tag !== 6'd30) begin n_bad++; $display("FAIL simul_head got v=%0b tag=%0d want v=1 tag=30", bus.o_cdb_valid, bus.o_cdb_tag); end
        step(1, 0, 2'd2, 0, 32'h20, 32'h0, 32'h0, 6'd31, 1, acc);
        n_cmp++; if (bus.o_issue_ready !== 1'b1) begin n_bad++; $display("FAIL simul_ready got %0b want 1", bus.o_issue_ready); end
        n_cmp++; if (bus.o_cdb_valid !== ((q.size() > 0) && (q[0].vis <= cyc))) begin n_bad++; $display("FAIL simul_valid got %0b want %0b", bus.o_cdb_valid, ((q.size() > 0) && (q[0].vis <= cyc))); end
        step(1, 0, 2'd2, 0, 32'h14, 32'h0, 32'h0, 6'd32, 0, acc);
        n_cmp++; if (bus.o_issue_ready !== 1'b0) begin n_bad++; $display("FAIL simul_credit got ready=%0b want 0", bus.o_issue_ready); end
        got = 0;
        for (int i = 0; i < 20 && got < 3; i++) begin
            if (bus.o_cdb_valid) begin
                n_cmp++;
                if (got >= 2 || bus.o_cdb_tag !== exp_tags[got]) begin n_bad++; $display("FAIL simul_order[%0d] got tag=%0d", got, bus.o_cdb_tag); end
                got++;
                idle(1);
            end else idle(0);
        end
        n_cmp++; if (got != 2) begin n_bad++; $display("FAIL simul_count got %0d results want 2", got); end
        n_cmp++; if (bus.o_issue_ready !== 1'b1) begin n_bad++; $display("FAIL simul_final_ready got %0b want 1", bus.o_issue_ready); end
    endtask

    task automatic test_reset_midflight();
        bit acc;
        step(1, 0, 2'd2, 0, 32'h14, 32'h0, 32'h0, 6'd40, 0, acc);
        rst_n = 1'b0;
        q.delete();
        credit = 0;
        #1;
        n_cmp++; if (bus.o_issue_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready_in_reset got %0b want 1", bus.o_issue_ready); end
        idle(0);
        idle(0);
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 3; i++) begin
            idle(0);
            n_cmp++; if (bus.o_cdb_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid cycle %0d got %0b want 0", i, bus.o_cdb_valid); end
        end
        n_cmp++; if (bus.o_issue_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready got %0b want 1", bus.o_issue_ready); end
    endtask

    task automatic test_misalign();
        bit acc;
        logic [31:0] exp_lw, exp_after;
`ifdef LSU_MISALIGN_CHK_EN
        exp_lw    = 32'hDEADBEEF;
        exp_after = 32'hA5A5A5A5;
`else
        exp_lw    = 32'hA5A5A5A5;
        exp_after = 32'h5A5AA5A5;
`endif
        step(1, 1, 2'd2, 0, 32'h20, 32'hA5A5A5A5, 32'h0, 6'd0, 0, acc);
        step(1, 0, 2'd2, 0, 32'h20, 32'h0, 32'h2, 6'd9, 0, acc);
        repeat (LAT) idle(0);
        n_cmp++; if (bus.o_cdb_tag !== 6'd9 || bus.o_cdb_result !== exp_lw) begin n_bad++; $display("FAIL misalign_lw got tag=%0d res=%h want tag=9 res=%h", bus.o_cdb_tag, bus.o_cdb_result, exp_lw); end
        idle(1);
        step(1, 1, 2'd1, 0, 32'h23, 32'h00005A5A, 32'h0, 6'd0, 0, acc);
        step(1, 0, 2'd2, 0, 32'h20, 32'h0, 32'h0, 6'd10, 0, acc);
        repeat (LAT) idle(0);
        n_cmp++; if (bus.o_cdb_tag !== 6'd10 || bus.o_cdb_result !== exp_after) begin n_bad++; $display("FAIL misalign_sh got tag=%0d res=%h want tag=10 res=%h", bus.o_cdb_tag, bus.o_cdb_result, exp_after); end
        idle(1);
    endtask

    task automatic test_random();
        bit acc, exp_v;
        for (int i = 0; i < 128; i++)
            step(1, 1, 2'd2, 0, 32'(i * 4), $urandom, 32'h0, 6'd0, 0, acc);
        for (int n = 0; n < 600; n++) begin
            exp_v = (q.size() > 0) && (q[0].vis <= cyc);
            n_cmp++; if (bus.o_issue_ready !== (credit < DEPTH)) begin n_bad++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", cyc, bus.o_issue_ready, (credit < DEPTH)); end
            n_cmp++; if (bus.o_cdb_valid !== exp_v) begin n_bad++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", cyc, bus.o_cdb_valid, exp_v); end
            if (exp_v) begin
                n_cmp++;
                if (bus.o_cdb_tag !== q[0].tag || bus.o_cdb_result !== q[0].data) begin
                    n_bad++; $display("FAIL rnd_head cyc %0d got tag=%0d res=%h want tag=%0d res=%h", cyc, bus.o_cdb_tag, bus.o_cdb_result, q[0].tag, q[0].data);
                end
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                 1'($urandom), $urandom, $urandom, 32'($urandom_range(0, 63)) - 32'd32,
                 6'($urandom), $urandom_range(0, 2) != 0, acc);
        end
        for (int i = 0; i < 30 && q.size() > 0; i++) idle(1);
        n_cmp++; if (q.size() != 0 || bus.o_cdb_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_drain left=%0d valid=%0b want 0/0", q.size(), bus.o_cdb_valid); end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        cyc    = 0;
        credit = 0;
        rst_n  = 1'b0;
        bus.i_issue_valid  = 1'b0;
        bus.i_ld_st_opcode = 1'b0;
        bus.i_size         = 2'd0;
        bus.i_unsigned     = 1'b0;
        bus.i_rs1_data     = 32'h0;
        bus.i_rs2_data     = 32'h0;
        bus.i_immediate    = 32'h0;
        bus.i_rd_tag       = 6'd0;
        bus.i_cdb_grant    = 1'b0;
        test_reset();
        test_word_store_load();
        test_byte_ext();
        test_backpressure();
        test_simul_accept_pop();
        test_reset_midflight();
        test_misalign();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout after %0d cycles", cyc);
        $fatal(1, "timeout");
    end

endmodule
